pistorm_ipl_event_fifo: RTL

Next-generation IPL capture block for the PiStorm CPLD/FPGA. It samples the 68k interrupt priority lines on M68K_CLK falling edges and passes them through a parametrised glitch filter. Every filtered level change is queued, with a bus-cycle timestamp, into a parametrised-depth FIFO that the Pi drains through the status register path. Compared with the fixed 3-bit/64-deep queue, it adds a configurable filter length, timestamps, a sticky overflow flag with read-to-clear, guaranteed delivery of the latest level after overflow, and a synchronous flush.

---
 rtl/pistorm_ipl_event_fifo.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/pistorm_ipl_event_fifo.sv
// Purpose: glitch-filtered 68k IPL level capture with timestamped change-event queue.
// Latency: IPL->LEVEL = FILTER_LEN ticks + 3-flop sync + 1 clk; LEVEL->COUNT 1 clk; POP->DATA_OUT 1 clk.
// Backpressure: full queue holds the newest level pending (sticky OVF) and retries every cycle until a POP frees space.
module pistorm_ipl_event_fifo #(
  parameter int IPL_W      = 3,
  parameter int DEPTH      = 64,
  parameter int FILTER_LEN = 2,
  parameter int TS_W       = 8,
  parameter int CNT_W      = 7
) (
  input  logic                      PI_CLK,
  input  logic                      RESET_n,
  input  logic                      M68K_CLK,
  input  logic [IPL_W-1:0]          M68K_IPL_n,
  input  logic                      CLR,
  input  logic                      POP,
  output logic [2+IPL_W+TS_W-1:0]   DATA_OUT,
  output logic [CNT_W-1:0]          COUNT,
  output logic                      NOT_EMPTY,
  output logic [IPL_W-1:0]          LEVEL
);

  localparam int ENT_W = IPL_W + TS_W;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

  // M68K_CLK synchroniser; bit 0 is the first stage
  logic [2:0]                        r_mclk_sync;
  logic [TS_W-1:0]                   r_ts;
  logic [FILTER_LEN-1:0][IPL_W-1:0]  r_samp;
  logic [IPL_W-1:0]                  r_level;
  logic [IPL_W-1:0]                  r_last_q;
  logic [PTR_W-1:0]                  r_wr_ptr;
  logic [PTR_W-1:0]                  r_rd_ptr;
  logic [CNT_W-1:0]                  r_count;
  logic                              r_not_empty;
  logic                              r_ovf;
  logic [2+ENT_W-1:0]                r_dout;
  logic [ENT_W-1:0]                  r_mem [DEPTH];

  logic                              w_tick;
  logic                              w_all_eq;
  logic                              w_empty;
  logic                              w_full;
  logic                              w_push_req;
  logic                              w_push;
  logic                              w_pop;
  logic                              w_ovf_set;
  logic [CNT_W-1:0]                  w_count_nxt;
  logic [PTR_W-1:0]                  w_wr_nxt;
  logic [PTR_W-1:0]                  w_rd_nxt;

  // Falling edge of the synchronised bus clock gives a one-cycle tick
  assign w_tick = r_mclk_sync[2] & ~r_mclk_sync[1];

  // Sample history must be unanimous before a new level is accepted
  always_comb begin
    w_all_eq = 1'b1;
    for (int i = 1; i < FILTER_LEN; i++) begin
      if (r_samp[i] != r_samp[0]) begin
        w_all_eq = 1'b0;
      end
    end
  end

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == DEPTH_C);
  assign w_push_req = (r_level != r_last_q);

  // A POP on a full queue always frees a slot in the same cycle, so it admits the push
  assign w_push    = w_push_req & ~CLR & (~w_full | POP);
  assign w_pop     = POP & ~CLR & ~w_empty;
  assign w_ovf_set = w_push_req & ~CLR & w_full & ~POP;

  assign w_wr_nxt = (r_wr_ptr == LAST_C) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_nxt = (r_rd_ptr == LAST_C) ? '0 : r_rd_ptr + 1'b1;

  // Occupancy: simultaneous push and pop leave it unchanged
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Bus-clock sync, timestamp and sample shift register; these keep running through CLR.
  // IPL is sampled raw: a metastable sample is just one more disagreeing entry for the filter.
  always_ff @(posedge PI_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_mclk_sync <= '0;
      r_ts        <= '0;
      r_samp      <= '0;
    end else begin
      r_mclk_sync <= {r_mclk_sync[1:0], M68K_CLK};
      if (w_tick) begin
        r_ts <= r_ts + 1'b1;
        for (int i = FILTER_LEN - 1; i > 0; i--) begin
          r_samp[i] <= r_samp[i-1];
        end
        r_samp[0] <= ~M68K_IPL_n;
      end
    end
  end

  // Filtered level follows the samples only once they all agree
  always_ff @(posedge PI_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_level <= '0;
    end else if (w_all_eq) begin
      r_level <= r_samp[0];
    end
  end

  // Queue bookkeeping; CLR wins over push and pop, and re-arms last_q so nothing is queued after a flush
  always_ff @(posedge PI_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_not_empty <= 1'b0;
      r_ovf       <= 1'b0;
      r_last_q    <= '0;
    end else if (CLR) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_not_empty <= 1'b0;
      r_ovf       <= 1'b0;
      r_last_q    <= r_level;
    end else begin
      if (w_push) begin
        r_wr_ptr <= w_wr_nxt;
        r_last_q <= r_level;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_nxt;
      end
      r_count     <= w_count_nxt;
      r_not_empty <= (w_count_nxt != '0);
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (POP) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Read port: head entry when something is queued, otherwise a live snapshot flagged not-valid
  always_ff @(posedge PI_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_dout <= '0;
    end else if (POP && !CLR) begin
      if (!w_empty) begin
        r_dout <= {1'b1, r_ovf, r_mem[r_rd_ptr]};
      end else begin
        r_dout <= {1'b0, r_ovf, r_level, r_ts};
      end
    end
  end

  // Entry storage; contents are only meaningful below COUNT, so it needs no reset
  always_ff @(posedge PI_CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {r_level, r_ts};
    end
  end

  assign DATA_OUT  = r_dout;
  assign COUNT     = r_count;
  assign NOT_EMPTY = r_not_empty;
  assign LEVEL     = r_level;

endmodule
